// File: rtl/ele_run_ctrl.sv
// ele_run_ctrl: elevator car motion and door sequencer for a 4-storey shaft.
// Moves a one-hot car position on a slow tick; stops, opens and times the door.
`default_nettype none

module ele_run_ctrl #(
  parameter int TRAVEL_TICKS = 4,
  parameter int DOOR_TICKS   = 6,
  parameter int CLOSE_TICKS  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [1:0] ud_mode,
  input  logic [3:0] eff_req,
  input  logic       door_btn,
  output logic [3:0] position,
  output logic       door_open,
  output logic       moving,
  output logic [1:0] run_dir,
  output logic       arrive
);

  localparam int MAX_A = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS;
  localparam int MAX_P = (MAX_A > CLOSE_TICKS) ? MAX_A : CLOSE_TICKS;
  localparam int CW    = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] TRAVEL_C = CW'(TRAVEL_TICKS);
  localparam logic [CW-1:0] DOOR_C   = CW'(DOOR_TICKS);
  localparam logic [CW-1:0] CLOSE_C  = CW'(CLOSE_TICKS);

  localparam logic [1:0] DIR_NONE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DN   = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MOVE    = 2'd1,
    OPEN    = 2'd2,
    CLOSING = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    pos_n;
  logic          door_n, mov_n, arr_n;
  logic [1:0]    dir_n;
  logic [3:0]    newpos;
  logic          at_end;

  // Candidate floor after one travel step in the latched trip direction.
  always_comb begin
    newpos = (run_dir == DIR_UP) ? {position[2:0], 1'b0} : {1'b0, position[3:1]};
    at_end = (run_dir == DIR_UP) ? newpos[3] : newpos[0];
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pos_n   = position;
    door_n  = door_open;
    mov_n   = moving;
    dir_n   = run_dir;
    arr_n   = 1'b0;
    case (state)
      IDLE: begin
        if (door_btn) begin
          state_n = OPEN;
          cnt_n   = DOOR_C;
          door_n  = 1'b1;
        end else if ((eff_req & position) != 4'b0000) begin
          state_n = OPEN;
          cnt_n   = DOOR_C;
          door_n  = 1'b1;
          arr_n   = 1'b1;
        end else if (ud_mode == DIR_UP && position != 4'b1000) begin
          state_n = MOVE;
          cnt_n   = TRAVEL_C;
          mov_n   = 1'b1;
          dir_n   = DIR_UP;
        end else if (ud_mode == DIR_DN && position != 4'b0001) begin
          state_n = MOVE;
          cnt_n   = TRAVEL_C;
          mov_n   = 1'b1;
          dir_n   = DIR_DN;
        end
      end
      MOVE: begin
        if (tick) begin
          if (cnt == ONE) begin
            pos_n = newpos;
            // End floors always stop the car, even without a request there.
            if (((eff_req & newpos) != 4'b0000) || at_end) begin
              state_n = OPEN;
              cnt_n   = DOOR_C;
              door_n  = 1'b1;
              mov_n   = 1'b0;
              dir_n   = DIR_NONE;
              arr_n   = 1'b1;
            end else begin
              cnt_n = TRAVEL_C;
            end
          end else begin
            cnt_n = cnt - ONE;
          end
        end
      end
      OPEN: begin
        if (door_btn) begin
          cnt_n = DOOR_C;
        end else if (tick) begin
          if (cnt == ONE) begin
            state_n = CLOSING;
            cnt_n   = CLOSE_C;
          end else begin
            cnt_n = cnt - ONE;
          end
        end
      end
      CLOSING: begin
        if (door_btn) begin
          state_n = OPEN;
          cnt_n   = DOOR_C;
        end else if (tick) begin
          if (cnt == ONE) begin
            state_n = IDLE;
            cnt_n   = '0;
            door_n  = 1'b0;
          end else begin
            cnt_n = cnt - ONE;
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      position  <= 4'b0001;
      door_open <= 1'b0;
      moving    <= 1'b0;
      run_dir   <= DIR_NONE;
      arrive    <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      position  <= pos_n;
      door_open <= door_n;
      moving    <= mov_n;
      run_dir   <= dir_n;
      arrive    <= arr_n;
    end
  end

endmodule

`default_nettype wire
